// File: rtl/date_day_pkg.sv
// Shared definitions for the day-of-week sequencing controller: command codes,
// request range limits, error day code and the controller state encoding.
package date_day_pkg;

    localparam logic [7:0] CMD_IDLE     = 8'h00;
    localparam logic [7:0] CMD_WR_YEAR  = 8'h05;
    localparam logic [7:0] CMD_WR_MONTH = 8'h09;
    localparam logic [7:0] CMD_WR_DATE  = 8'h0D;
    localparam logic [7:0] CMD_RD_DAY   = 8'h03;

    localparam logic [15:0] YEAR_MIN  = 16'd1900;
    localparam logic [15:0] YEAR_MAX  = 16'd2019;
    localparam logic [15:0] MONTH_MAX = 16'd12;
    localparam logic [15:0] DATE_MAX  = 16'd31;

    localparam logic [2:0] DAY_ERR = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_YEAR,
        ST_GAP1,
        ST_WR_MONTH,
        ST_GAP2,
        ST_WR_DATE,
        ST_GAP3,
        ST_RD_DAY,
        ST_RESP
    } state_t;

    // Command presented to the day-of-week unit while in a given state.
    function automatic logic [7:0] state_cmd(input state_t st);
        case (st)
            ST_WR_YEAR:  return CMD_WR_YEAR;
            ST_WR_MONTH: return CMD_WR_MONTH;
            ST_WR_DATE:  return CMD_WR_DATE;
            ST_RD_DAY:   return CMD_RD_DAY;
            default:     return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/date_day_range_chk.sv
// Combinational validator: flags a (year, month, date) request that the
// day-of-week unit can handle.
module date_day_range_chk
    import date_day_pkg::*;
(
    input  logic [15:0] year,
    input  logic [15:0] month,
    input  logic [15:0] date,
    output logic        in_range
);

    logic year_ok;
    logic month_ok;
    logic date_ok;

    assign year_ok  = (year >= YEAR_MIN) && (year <= YEAR_MAX);
    assign month_ok = (month >= 16'd1) && (month <= MONTH_MAX);
    assign date_ok  = (date >= 16'd1) && (date <= DATE_MAX);
    assign in_range = year_ok && month_ok && date_ok;

endmodule

// File: rtl/date_day_ctrl.sv
// Sequences a (year, month, date) request through the day-of-week unit's
// write-year / write-month / write-date / read-day commands and returns the day.
module date_day_ctrl
    import date_day_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic [15:0] Req_year,
    input  logic [15:0] Req_month,
    input  logic [15:0] Req_date,
    output logic        Resp_valid,
    input  logic        Resp_ready,
    output logic [2:0]  Resp_day,
    output logic        Resp_error,
    output logic [7:0]  Dd_command,
    output logic [15:0] Dd_data_in,
    input  logic [15:0] Dd_data_out
);

    localparam int MAX_HOLD = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      month_reg, month_next;
    logic [15:0]      date_reg, date_next;
    logic [15:0]      data_in_reg, data_in_next;
    logic [2:0]       resp_day_reg, resp_day_next;
    logic             resp_error_reg, resp_error_next;
    logic             in_range;
    logic             cnt_done;

    date_day_range_chk u_range_chk (
        .year     (Req_year),
        .month    (Req_month),
        .date     (Req_date),
        .in_range (in_range)
    );

    assign cnt_done = (cnt_reg == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            month_reg      <= '0;
            date_reg       <= '0;
            data_in_reg    <= '0;
            resp_day_reg   <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            month_reg      <= month_next;
            date_reg       <= date_next;
            data_in_reg    <= data_in_next;
            resp_day_reg   <= resp_day_next;
            resp_error_reg <= resp_error_next;
        end
    end

    // The hold counter free-runs down to zero; each state leaves on zero and
    // reloads it for the state it enters.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_done ? cnt_reg : cnt_reg - 1'b1;
        month_next      = month_reg;
        date_next       = date_reg;
        data_in_next    = data_in_reg;
        resp_day_next   = resp_day_reg;
        resp_error_next = resp_error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (Req_valid) begin
                    month_next = Req_month;
                    date_next  = Req_date;
                    if (in_range) begin
                        state_next   = ST_WR_YEAR;
                        cnt_next     = SETTLE_LOAD;
                        data_in_next = Req_year;
                    end else begin
                        state_next      = ST_RESP;
                        resp_day_next   = DAY_ERR;
                        resp_error_next = 1'b1;
                    end
                end
            end
            ST_WR_YEAR: begin
                if (cnt_done) begin
                    state_next = ST_GAP1;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_GAP1: begin
                if (cnt_done) begin
                    state_next   = ST_WR_MONTH;
                    cnt_next     = SETTLE_LOAD;
                    data_in_next = month_reg;
                end
            end
            ST_WR_MONTH: begin
                if (cnt_done) begin
                    state_next = ST_GAP2;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_GAP2: begin
                if (cnt_done) begin
                    state_next   = ST_WR_DATE;
                    cnt_next     = SETTLE_LOAD;
                    data_in_next = date_reg;
                end
            end
            ST_WR_DATE: begin
                if (cnt_done) begin
                    state_next = ST_GAP3;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_GAP3: begin
                if (cnt_done) begin
                    state_next   = ST_RD_DAY;
                    cnt_next     = SETTLE_LOAD;
                    data_in_next = '0;
                end
            end
            ST_RD_DAY: begin
                // Sample only on the last settle cycle so the unit's output is stable.
                if (cnt_done) begin
                    state_next = ST_RESP;
                    if (Dd_data_out <= 16'd6) begin
                        resp_day_next   = Dd_data_out[2:0];
                        resp_error_next = 1'b0;
                    end else begin
                        resp_day_next   = DAY_ERR;
                        resp_error_next = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (Resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Req_ready  = (state_reg == ST_IDLE);
    assign Resp_valid = (state_reg == ST_RESP);
    assign Resp_day   = resp_day_reg;
    assign Resp_error = resp_error_reg;
    assign Dd_command = state_cmd(state_reg);
    assign Dd_data_in = data_in_reg;

endmodule

// File: tb/tb_date_day_ctrl.sv
// Directed bench for date_day_ctrl with a behavioural stand-in for the
// day-of-week unit that records writes and returns a bench-chosen day code.
module tb_date_day_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req_valid = 1'b0;
    logic        Req_ready;
    logic [15:0] Req_year = '0;
    logic [15:0] Req_month = '0;
    logic [15:0] Req_date = '0;
    logic        Resp_valid;
    logic        Resp_ready = 1'b1;
    logic [2:0]  Resp_day;
    logic        Resp_error;
    logic [7:0]  Dd_command;
    logic [15:0] Dd_data_in;
    logic [15:0] Dd_data_out;

    int total = 0;
    int bad = 0;

    logic [15:0] stub_out = '0;
    logic        cap_clr = 1'b0;
    logic [15:0] cap_year, cap_month, cap_date, cap_rd;

    logic [7:0] exp_cmd [0:12] = '{8'h00, 8'h05, 8'h05, 8'h00, 8'h09, 8'h09, 8'h00,
                                   8'h0D, 8'h0D, 8'h00, 8'h03, 8'h03, 8'h00};

    date_day_ctrl #(.SETTLE_CYCLES(2), .GAP_CYCLES(1)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req_valid   (Req_valid),
        .Req_ready   (Req_ready),
        .Req_year    (Req_year),
        .Req_month   (Req_month),
        .Req_date    (Req_date),
        .Resp_valid  (Resp_valid),
        .Resp_ready  (Resp_ready),
        .Resp_day    (Resp_day),
        .Resp_error  (Resp_error),
        .Dd_command  (Dd_command),
        .Dd_data_in  (Dd_data_in),
        .Dd_data_out (Dd_data_out)
    );

    always #5 Clk = ~Clk;

    // Stand-in unit: drives the day code only while read-day is commanded.
    assign Dd_data_out = (Dd_command == 8'h03) ? stub_out : 16'hFFFF;

    always @(posedge Clk) begin
        if (cap_clr) begin
            cap_year  <= 16'hFFFF;
            cap_month <= 16'hFFFF;
            cap_date  <= 16'hFFFF;
            cap_rd    <= 16'hFFFF;
        end else begin
            if (Dd_command == 8'h05) cap_year  <= Dd_data_in;
            if (Dd_command == 8'h09) cap_month <= Dd_data_in;
            if (Dd_command == 8'h0D) cap_date  <= Dd_data_in;
            if (Dd_command == 8'h03) cap_rd    <= Dd_data_in;
        end
    end

    task automatic chk(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // Issues one request starting just after a negedge; returns at the negedge
    // where the response is first visible (or the cycle budget expires).
    task automatic run_req(input string tag, input logic [15:0] y, input logic [15:0] m,
                           input logic [15:0] d, input logic [15:0] stub, input int exp_cyc,
                           input logic [2:0] exp_day, input logic exp_err);
        int   cyc;
        logic cmd_ok;
        logic nonidle;
        stub_out = stub;
        cap_clr  = 1'b1;
        @(negedge Clk);
        cap_clr = 1'b0;
        chk(tag, "req_ready", Req_ready, 1);
        chk(tag, "cmd_idle", Dd_command, 8'h00);
        Req_valid = 1'b1;
        Req_year  = y;
        Req_month = m;
        Req_date  = d;
        @(negedge Clk);
        Req_valid = 1'b0;
        Req_year  = 16'd1999;
        Req_month = 16'd2;
        Req_date  = 16'd3;
        cyc     = 1;
        cmd_ok  = 1'b1;
        nonidle = 1'b0;
        while (!Resp_valid && cyc < 40) begin
            if (cyc <= 12 && Dd_command !== exp_cmd[cyc]) cmd_ok = 1'b0;
            if (Dd_command != 8'h00) nonidle = 1'b1;
            @(negedge Clk);
            cyc++;
        end
        chk(tag, "resp_cycle", cyc, exp_cyc);
        chk(tag, "resp_day", Resp_day, exp_day);
        chk(tag, "resp_error", Resp_error, exp_err);
        chk(tag, "resp_cmd", Dd_command, 8'h00);
        if (exp_cyc == 12) begin
            chk(tag, "cmd_seq", cmd_ok, 1);
            chk(tag, "wr_year", cap_year, y);
            chk(tag, "wr_month", cap_month, m);
            chk(tag, "wr_date", cap_date, d);
            chk(tag, "rd_data_in", cap_rd, 0);
        end else begin
            chk(tag, "no_cmds", nonidle, 0);
        end
        $display("req %s %0d/%0d/%0d -> cycle=%0d day=%0d err=%0d", tag, y, m, d, cyc,
                 Resp_day, Resp_error);
    endtask

    task automatic resp_done(input string tag);
        @(negedge Clk);
        chk(tag, "ready_after", Req_ready, 1);
        chk(tag, "valid_after", Resp_valid, 0);
    endtask

    initial begin
        logic [2:0] d0;
        logic       e0;
        logic       hold_ok;
        logic       quiet_ok;
        int         n;

        // Reset values while Reset_n is held low.
        repeat (3) @(negedge Clk);
        chk("reset", "cmd", Dd_command, 8'h00);
        chk("reset", "data_in", Dd_data_in, 0);
        chk("reset", "resp_valid", Resp_valid, 0);
        chk("reset", "resp_day", Resp_day, 0);
        chk("reset", "resp_error", Resp_error, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset", "req_ready", Req_ready, 1);
        $display("reset released");

        // In-range requests; the stub day code is the expected unit answer.
        run_req("d2000_1_1", 16'd2000, 16'd1, 16'd1, 16'd0, 12, 3'd0, 1'b0);
        resp_done("d2000_1_1");
        run_req("d2010_3_15", 16'd2010, 16'd3, 16'd15, 16'd1, 12, 3'd1, 1'b0);
        resp_done("d2010_3_15");
        run_req("d1969_7_20", 16'd1969, 16'd7, 16'd20, 16'd0, 12, 3'd0, 1'b0);
        resp_done("d1969_7_20");
        run_req("d1900_1_1", 16'd1900, 16'd1, 16'd1, 16'd5, 12, 3'd5, 1'b0);
        resp_done("d1900_1_1");
        run_req("d2019_12_31", 16'd2019, 16'd12, 16'd31, 16'd6, 12, 3'd6, 1'b0);
        resp_done("d2019_12_31");

        // Out-of-range requests answer in cycle 1 without touching the unit.
        run_req("year2024", 16'd2024, 16'd5, 16'd5, 16'd2, 1, 3'd7, 1'b1);
        resp_done("year2024");
        run_req("year1899", 16'd1899, 16'd5, 16'd5, 16'd2, 1, 3'd7, 1'b1);
        resp_done("year1899");
        run_req("month13", 16'd2000, 16'd13, 16'd1, 16'd2, 1, 3'd7, 1'b1);
        resp_done("month13");
        run_req("month0", 16'd2000, 16'd0, 16'd1, 16'd2, 1, 3'd7, 1'b1);
        resp_done("month0");
        run_req("date0", 16'd2000, 16'd1, 16'd0, 16'd2, 1, 3'd7, 1'b1);
        resp_done("date0");
        run_req("date32", 16'd2000, 16'd1, 16'd32, 16'd2, 1, 3'd7, 1'b1);
        resp_done("date32");

        // Unit returning an out-of-range code.
        run_req("dp_ffff", 16'd2000, 16'd1, 16'd1, 16'hFFFF, 12, 3'd7, 1'b1);
        resp_done("dp_ffff");
        run_req("dp_7", 16'd2000, 16'd1, 16'd1, 16'd7, 12, 3'd7, 1'b1);
        resp_done("dp_7");
        run_req("dp_100", 16'd2000, 16'd1, 16'd1, 16'd100, 12, 3'd7, 1'b1);
        resp_done("dp_100");

        // Backpressure: response held, a request pulse must not be taken.
        Resp_ready = 1'b0;
        run_req("bp", 16'd2000, 16'd1, 16'd1, 16'd4, 12, 3'd4, 1'b0);
        d0 = Resp_day;
        e0 = Resp_error;
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                Req_valid = 1'b1;
                Req_year  = 16'd2000;
                Req_month = 16'd1;
                Req_date  = 16'd1;
            end
            if (i == 6) Req_valid = 1'b0;
            @(negedge Clk);
            if (Resp_valid !== 1'b1 || Resp_day !== d0 || Resp_error !== e0 ||
                Req_ready !== 1'b0 || Dd_command !== 8'h00) hold_ok = 1'b0;
        end
        chk("bp", "held_stable", hold_ok, 1);
        Resp_ready = 1'b1;
        @(negedge Clk);
        chk("bp", "ready_after", Req_ready, 1);
        chk("bp", "valid_after", Resp_valid, 0);
        quiet_ok = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (Dd_command !== 8'h00 || Resp_valid !== 1'b0) quiet_ok = 1'b0;
        end
        chk("bp", "pulse_ignored", quiet_ok, 1);
        $display("backpressure window done day=%0d", d0);

        // Asynchronous reset in the middle of WR_MONTH drops the request.
        stub_out = 16'd0;
        Req_valid = 1'b1;
        Req_year  = 16'd2000;
        Req_month = 16'd1;
        Req_date  = 16'd1;
        @(negedge Clk);
        Req_valid = 1'b0;
        n = 0;
        while (Dd_command !== 8'h09 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("rst_mid", "reach_wr_month", Dd_command, 8'h09);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_mid", "cmd", Dd_command, 8'h00);
        chk("rst_mid", "data_in", Dd_data_in, 0);
        chk("rst_mid", "resp_valid", Resp_valid, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        quiet_ok = 1'b1;
        repeat (16) begin
            @(negedge Clk);
            if (Resp_valid !== 1'b0 || Dd_command !== 8'h00 || Req_ready !== 1'b1)
                quiet_ok = 1'b0;
        end
        chk("rst_mid", "dropped", quiet_ok, 1);
        $display("mid-sequence reset done");
        run_req("after_rst", 16'd2000, 16'd1, 16'd1, 16'd0, 12, 3'd0, 1'b0);
        resp_done("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
